// File: rtl/ex_mc_pkg.sv
// Shared opcode constants and divider state encoding for the EX stage.
package ex_defs;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_MFHI = 8'h10;
    localparam logic [7:0] OP_MTHI = 8'h11;
    localparam logic [7:0] OP_MFLO = 8'h12;
    localparam logic [7:0] OP_MTLO = 8'h13;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLL  = 8'h7C;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/ex_mc_if.sv
// Bus bundles: the EX issue/result bus and the EX-to-divider link.

// Issue handshake: stallreq is the inverse of ready. An instruction on the
// bus is consumed on a rising edge where stallreq=0; while stallreq=1 the
// upstream stage must hold aluop/reg1/reg2/wd/wreg stable. annul is not
// flow-controlled and kills whatever is being presented that cycle.
interface ex_mc_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8
) ();
    logic [ALUOP_W-1:0]    aluop;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic                  annul;
    logic [DATA_W-1:0]     wdata;
    logic [REG_ADDR_W-1:0] wd_out;
    logic                  wreg_out;
    logic                  stallreq;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;

    modport master (output aluop, reg1, reg2, wd, wreg, annul,
                    input  wdata, wd_out, wreg_out, stallreq, hi, lo);
    modport slave  (input  aluop, reg1, reg2, wd, wreg, annul,
                    output wdata, wd_out, wreg_out, stallreq, hi, lo);
endinterface

interface div_if #(
    parameter int DATA_W = 32
) ();
    import ex_defs::*;
    logic              start;
    logic              sgn;
    logic              annul;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              done;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;
    div_state_e        state;

    modport master (output start, sgn, annul, op_a, op_b,
                    input  done, quotient, remainder, state);
    modport slave  (input  start, sgn, annul, op_a, op_b,
                    output done, quotient, remainder, state);
endinterface

// File: rtl/ex_mc_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, sign fix-up applied on the way out.
module div_iter
    import ex_defs::*;
#(
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave div
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] den_q, den_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;

    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   shifted, diff;

    always_comb begin
        a_mag   = (div.sgn && div.op_a[DATA_W-1]) ? -div.op_a : div.op_a;
        b_mag   = (div.sgn && div.op_b[DATA_W-1]) ? -div.op_b : div.op_b;
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, den_q};

        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        den_d   = den_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;

        if (div.annul) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div.start) begin
                        if (div.op_b == '0) begin
                            // Divide by zero: results are fixed, no signs applied.
                            quo_d   = '1;
                            rem_d   = div.op_a;
                            qneg_d  = 1'b0;
                            rneg_d  = 1'b0;
                            state_d = DIV_DONE;
                        end else begin
                            quo_d   = a_mag;
                            rem_d   = '0;
                            den_d   = b_mag;
                            cnt_d   = '0;
                            qneg_d  = div.sgn & (div.op_a[DATA_W-1] ^ div.op_b[DATA_W-1]);
                            rneg_d  = div.sgn & div.op_a[DATA_W-1];
                            state_d = DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (!diff[DATA_W]) begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            den_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            den_q   <= den_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign div.done      = (state_q == DIV_DONE);
    assign div.quotient  = qneg_q ? -quo_q : quo_q;
    assign div.remainder = rneg_q ? -rem_q : rem_q;
    assign div.state     = state_q;

endmodule

// File: rtl/ex_mc.sv
// EX stage: single-cycle ALU, HI/LO registers, multi-cycle divide with
// upstream stall, and the registered result towards MEM.
module ex_mc
    import ex_defs::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALUOP_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALUOP_W-1:0]    aluop_i,
    input  logic [DATA_W-1:0]     reg1_i,
    input  logic [DATA_W-1:0]     reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  annul_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic                  stallreq_o,
    output logic [DATA_W-1:0]     hi_o,
    output logic [DATA_W-1:0]     lo_o
);
    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0]     hi_q, hi_d;
    logic [DATA_W-1:0]     lo_q, lo_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;

    logic              is_div;
    logic              stall;
    logic [SH_W-1:0]   shamt;
    logic [DATA_W-1:0] alu_res;

    div_if #(.DATA_W(DATA_W)) div_bus ();

    assign is_div        = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign div_bus.start = is_div;
    assign div_bus.sgn   = (aluop_i == OP_DIV);
    assign div_bus.annul = annul_i;
    assign div_bus.op_a  = reg1_i;
    assign div_bus.op_b  = reg2_i;

    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk (clk),
        .rst (rst),
        .div (div_bus)
    );

    // The divide stalls until its DONE cycle, where the result retires.
    assign stall      = !rst && is_div && !annul_i && (div_bus.state != DIV_DONE);
    assign stallreq_o = stall;
    assign shamt      = reg1_i[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (aluop_i)
            OP_OR:   alu_res = reg1_i | reg2_i;
            OP_AND:  alu_res = reg1_i & reg2_i;
            OP_XOR:  alu_res = reg1_i ^ reg2_i;
            OP_NOR:  alu_res = ~(reg1_i | reg2_i);
            OP_ADDU: alu_res = reg1_i + reg2_i;
            OP_SUBU: alu_res = reg1_i - reg2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
            OP_SLL:  alu_res = reg2_i << shamt;
            OP_SRL:  alu_res = reg2_i >> shamt;
            OP_SRA:  alu_res = $signed(reg2_i) >>> shamt;
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (!annul_i) begin
            if (div_bus.done) begin
                hi_d = div_bus.remainder;
                lo_d = div_bus.quotient;
            end else if (aluop_i == OP_MTHI) begin
                hi_d = reg1_i;
            end else if (aluop_i == OP_MTLO) begin
                lo_d = reg1_i;
            end
        end
    end

    always_comb begin
        wdata_d = '0;
        wd_d    = '0;
        wreg_d  = 1'b0;
        if (!stall && !annul_i) begin
            wdata_d = alu_res;
            wd_d    = wd_i;
            wreg_d  = wreg_i & ~is_div;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q    <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
        end else begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
        end
    end

    assign wdata_o = wdata_q;
    assign wd_o    = wd_q;
    assign wreg_o  = wreg_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_ex_mc.sv
// Self-checking bench for ex_mc: scoreboarded ALU results, divide timing,
// annul and reset-abort behaviour.
module tb_ex_mc;
    import ex_defs::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int OW = 8;
    localparam int W  = DW + AW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_mc_if #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW)) bus ();

    ex_mc #(.DATA_W(DW), .REG_ADDR_W(AW), .ALUOP_W(OW)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (bus.aluop),
        .reg1_i     (bus.reg1),
        .reg2_i     (bus.reg2),
        .wd_i       (bus.wd),
        .wreg_i     (bus.wreg),
        .annul_i    (bus.annul),
        .wdata_o    (bus.wdata),
        .wd_o       (bus.wd_out),
        .wreg_o     (bus.wreg_out),
        .stallreq_o (bus.stallreq),
        .hi_o       (bus.hi),
        .lo_o       (bus.lo)
    );

    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] m_hi = '0;
    logic [DW-1:0] m_lo = '0;
    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] op_tab [0:14] = '{OP_OR, OP_AND, OP_XOR, OP_NOR, OP_ADDU, OP_SUBU, OP_SLT,
                                  OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MTHI,
                                  OP_MTLO, 8'h55};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_alu(input logic [7:0] op,
                                                input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        r = '0;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_ADDU: r = a + b;
            OP_SUBU: r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLL:  r = b << a[4:0];
            OP_SRL:  r = b >> a[4:0];
            OP_SRA:  r = $signed(b) >>> a[4:0];
            OP_MFHI: r = m_hi;
            OP_MFLO: r = m_lo;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [AW-1:0] wd, input logic wreg, input logic annul);
        bus.aluop = op;
        bus.reg1  = a;
        bus.reg2  = b;
        bus.wd    = wd;
        bus.wreg  = wreg;
        bus.annul = annul;
    endtask

    task automatic check_out(input string tag);
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 64'({bus.wdata, bus.wd_out, bus.wreg_out}), 64'(e));
        end
    endtask

    task automatic check_hilo(input string tag);
        check({tag, "_hi"}, 64'(bus.hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic run_op(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [AW-1:0] wd, input logic wreg);
        drive(op, a, b, wd, wreg, 1'b0);
        exp_q.push_back({model_alu(op, a, b), wd, wreg});
        @(posedge clk);
        #1;
        if (op == OP_MTHI) m_hi = a;
        if (op == OP_MTLO) m_lo = a;
        check_out("op_out");
        check_hilo("op");
    endtask

    task automatic run_div(input logic [7:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [AW-1:0] wd, input int exp_stall);
        int stalls;
        logic [DW-1:0] q, r;
        stalls = 0;
        drive(op, a, b, wd, 1'b1, 1'b0);
        @(negedge clk);
        while (bus.stallreq && stalls < 100) begin
            stalls++;
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            check_out("div_bubble");
            @(negedge clk);
        end
        check("div_stall_cycles", 64'(stalls), 64'(exp_stall));
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (op == OP_DIV) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        exp_q.push_back({{DW{1'b0}}, wd, 1'b0});
        @(posedge clk);
        #1;
        m_hi = r;
        m_lo = q;
        check_out("div_done_out");
        check_hilo("div");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]    op;
        logic [DW-1:0] a, b;

        // Reset with a divide presented: no stall, everything cleared.
        rst = 1'b1;
        drive(OP_DIV, 32'd100, 32'd3, 5'd7, 1'b1, 1'b0);
        @(negedge clk);
        check("rst_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk);
        #1;
        check("rst_out", 64'({bus.wdata, bus.wd_out, bus.wreg_out}), 64'd0);
        check_hilo("rst");
        rst = 1'b0;
        drive(OP_NOP, '0, '0, '0, 1'b0, 1'b0);

        run_op(OP_OR, 32'h0F0F0000, 32'h000000FF, 5'd3, 1'b1);
        check("or_vector", 64'(bus.wdata), 64'h0F0F00FF);

        run_op(OP_MTHI, 32'h12345678, 32'h0, 5'd0, 1'b1);
        run_op(OP_MFHI, 32'h0, 32'h0, 5'd9, 1'b1);
        check("mfhi_fwd", 64'(bus.wdata), 64'h12345678);
        run_op(OP_MTLO, 32'hCAFEBABE, 32'h0, 5'd0, 1'b0);
        run_op(OP_MFLO, 32'h0, 32'h0, 5'd10, 1'b1);
        run_op(OP_SRA, 32'd4, 32'h80000000, 5'd11, 1'b1);
        run_op(OP_SLT, 32'hFFFFFFFF, 32'd1, 5'd12, 1'b1);
        run_op(OP_NOP, 32'hFFFF, 32'hFFFF, 5'd13, 1'b1);

        run_div(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd4, 33);
        check("div_neg_lo", 64'(bus.lo), 64'hFFFFFFFD);
        check("div_neg_hi", 64'(bus.hi), 64'hFFFFFFFF);

        run_div(OP_DIVU, 32'd100, 32'd0, 5'd5, 1);
        check("dbz_lo", 64'(bus.lo), 64'hFFFFFFFF);
        check("dbz_hi", 64'(bus.hi), 64'd100);

        run_div(OP_DIV, 32'd7, 32'hFFFFFFFE, 5'd6, 33);
        run_div(OP_DIV, 32'hFFFFFFF8, 32'hFFFFFFFD, 5'd7, 33);
        run_div(OP_DIVU, 32'hFFFFFFFF, 32'd3, 5'd8, 33);

        // Annul in the tenth cycle of a divide.
        run_op(OP_MTHI, 32'h0000AAAA, 32'h0, 5'd0, 1'b0);
        run_op(OP_MTLO, 32'h00005555, 32'h0, 5'd0, 1'b0);
        drive(OP_DIVU, 32'd1000, 32'd7, 5'd2, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            check("annul_pre_stall", 64'(bus.stallreq), 64'd1);
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            check_out("annul_pre_out");
        end
        bus.annul = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(bus.stallreq), 64'd0);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        check_out("annul_out");
        check_hilo("annul");
        drive(OP_NOP, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clk);
        check("post_annul_stall", 64'(bus.stallreq), 64'd0);
        for (int i = 0; i < 3; i++) run_op(OP_NOP, '0, '0, 5'd0, 1'b0);
        run_div(OP_DIVU, 32'd9, 32'd2, 5'd1, 33);

        // Annul on a single-cycle op gives a bubble.
        drive(OP_OR, 32'd1, 32'd2, 5'd3, 1'b1, 1'b1);
        exp_q.push_back('0);
        @(posedge clk);
        #1;
        check_out("annul_or");

        for (int i = 0; i < 40; i++) begin
            op = op_tab[$urandom_range(0, 14)];
            run_op(op, $urandom, $urandom, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 4; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            if (op == OP_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            run_div(op, a, b, AW'(i), (b == '0) ? 1 : 33);
        end

        // Reset in the middle of a divide.
        run_op(OP_MTHI, 32'h11, 32'h0, 5'd0, 1'b0);
        run_op(OP_MTLO, 32'h22, 32'h0, 5'd0, 1'b0);
        drive(OP_DIV, 32'd1234, 32'd5, 5'd6, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back('0);
            @(posedge clk);
            #1;
            check_out("rstdiv_bubble");
        end
        rst = 1'b1;
        @(negedge clk);
        check("rstdiv_stall", 64'(bus.stallreq), 64'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("rstdiv_out", 64'({bus.wdata, bus.wd_out, bus.wreg_out}), 64'd0);
        check_hilo("rstdiv");
        drive(OP_NOP, '0, '0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check_hilo("rstdiv_after");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
